// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline run/step controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

   // State encodings are visible to the debug unit through o_state, so they are fixed.
   localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
   localparam logic [2:0] ST_RUN_ENC       = 3'd1;
   localparam logic [2:0] ST_STEP_WAIT_ENC = 3'd2;
   localparam logic [2:0] ST_STEP_EXEC_ENC = 3'd3;
   localparam logic [2:0] ST_DRAIN_ENC     = 3'd4;
   localparam logic [2:0] ST_HALTED_ENC    = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE      = ST_IDLE_ENC,
      ST_RUN       = ST_RUN_ENC,
      ST_STEP_WAIT = ST_STEP_WAIT_ENC,
      ST_STEP_EXEC = ST_STEP_EXEC_ENC,
      ST_DRAIN     = ST_DRAIN_ENC,
      ST_HALTED    = ST_HALTED_ENC
   } run_state_t;

   // Enabled cycles needed to empty ID..WB once HALT has been decoded in ID.
   localparam int DRAIN_CYCLES_DEF = 4;

   // Width of the debug cycle/stall counters.
   localparam int COUNT_BITS_DEF = 32;

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard detect: load in EX whose destination feeds an ID-stage source.
// Latency: purely combinational, same cycle.
// Backpressure: none; i_enable gates detection while the pipeline is frozen.
module load_use_detector #(
   parameter int BITS_REGS = 5
)(
   input  logic                 i_enable,
   input  logic                 i_idex_mem_read,
   input  logic [BITS_REGS-1:0] i_idex_rt,
   input  logic [BITS_REGS-1:0] i_ifid_rs,
   input  logic [BITS_REGS-1:0] i_ifid_rt,
   output logic                 o_stall
);

   logic w_rt_nonzero;
   logic w_src_match;

   // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
   always_comb begin
      w_rt_nonzero = (i_idex_rt != '0);
      w_src_match  = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
      o_stall      = i_enable & i_idex_mem_read & w_rt_nonzero & w_src_match;
   end

endmodule

// File: rtl/pipeline_run_control.sv
// Run/step sequencer and load-use/branch/HALT hazard control for the 5-stage pipeline.
// Latency: control outputs combinational from state + hazard inputs; state, step_done, counters registered.
// Backpressure: pipeline frozen outside RUN/STEP_EXEC/DRAIN; load-use stall holds PC and IF/ID.
module pipeline_run_control
   import pipeline_ctrl_pkg::*;
#(
   parameter int BITS_REGS    = 5,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int COUNT_BITS   = COUNT_BITS_DEF
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_step_mode,
   input  logic                  i_step_req,
   input  logic                  i_halt_detected,
   input  logic                  i_branch_taken,
   input  logic                  i_IDEX_mem_read,
   input  logic [BITS_REGS-1:0]  i_IDEX_rt,
   input  logic [BITS_REGS-1:0]  i_IFID_rs,
   input  logic [BITS_REGS-1:0]  i_IFID_rt,
   output logic                  o_pipe_enable,
   output logic                  o_pc_enable,
   output logic                  o_ifid_write,
   output logic                  o_ifid_flush,
   output logic                  o_idex_bubble,
   output logic                  o_step_done,
   output logic                  o_halted,
   output logic [2:0]            o_state,
   output logic [COUNT_BITS-1:0] o_cycle_count,
   output logic [COUNT_BITS-1:0] o_stall_count
);

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   run_state_t            r_state;
   run_state_t            w_next_state;
   logic [DRAIN_W-1:0]    r_drain_cnt;
   logic                  r_step_done;
   logic [COUNT_BITS-1:0] r_cycle_count;
   logic [COUNT_BITS-1:0] r_stall_count;

   logic w_pipe_enable;
   logic w_stall;
   logic w_pc_enable;
   logic w_ifid_write;
   logic w_ifid_flush;
   logic w_idex_bubble;

   // Moore enable: only the state decides whether stage registers advance.
   always_comb begin
      w_pipe_enable = (r_state == ST_RUN) || (r_state == ST_STEP_EXEC) || (r_state == ST_DRAIN);
   end

   load_use_detector #(
      .BITS_REGS (BITS_REGS)
   ) u_load_use (
      .i_enable        (w_pipe_enable),
      .i_idex_mem_read (i_IDEX_mem_read),
      .i_idex_rt       (i_IDEX_rt),
      .i_ifid_rs       (i_IFID_rs),
      .i_ifid_rt       (i_IFID_rt),
      .o_stall         (w_stall)
   );

   // Next state and hazard priority: stall beats HALT beats branch; a stalled HALT is re-seen next cycle.
   always_comb begin
      w_next_state  = r_state;
      w_pc_enable   = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_next_state = i_step_mode ? ST_STEP_WAIT : ST_RUN;
            end
         end
         ST_RUN, ST_STEP_EXEC: begin
            // A step always returns to waiting after its single enabled cycle.
            if (r_state == ST_STEP_EXEC) begin
               w_next_state = ST_STEP_WAIT;
            end
            if (w_stall) begin
               w_idex_bubble = 1'b1;
            end else if (i_halt_detected) begin
               w_ifid_flush = 1'b1;
               w_next_state = ST_DRAIN;
            end else if (i_branch_taken) begin
               w_pc_enable  = 1'b1;
               w_ifid_write = 1'b1;
               w_ifid_flush = 1'b1;
            end else begin
               w_pc_enable  = 1'b1;
               w_ifid_write = 1'b1;
            end
         end
         ST_STEP_WAIT: begin
            if (i_step_req) begin
               w_next_state = ST_STEP_EXEC;
            end
         end
         ST_DRAIN: begin
            // Keep feeding NOPs behind the HALT; a bubble is still honoured if ever requested.
            w_ifid_flush  = 1'b1;
            w_idex_bubble = w_stall;
            if (r_drain_cnt == DRAIN_W'(1)) begin
               w_next_state = ST_HALTED;
            end
         end
         ST_HALTED: begin
            w_next_state = ST_HALTED;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State register, drain down-counter, step-done pulse and debug counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_drain_cnt   <= '0;
         r_step_done   <= 1'b0;
         r_cycle_count <= '0;
         r_stall_count <= '0;
      end else begin
         r_state     <= w_next_state;
         r_step_done <= (r_state == ST_STEP_EXEC);
         if ((w_next_state == ST_DRAIN) && (r_state != ST_DRAIN)) begin
            r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
         end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
         end
         if (w_pipe_enable) begin
            r_cycle_count <= r_cycle_count + COUNT_BITS'(1);
         end
         if (w_stall) begin
            r_stall_count <= r_stall_count + COUNT_BITS'(1);
         end
      end
   end

   // Output assignments.
   always_comb begin
      o_pipe_enable = w_pipe_enable;
      o_pc_enable   = w_pc_enable;
      o_ifid_write  = w_ifid_write;
      o_ifid_flush  = w_ifid_flush;
      o_idex_bubble = w_idex_bubble;
      o_step_done   = r_step_done;
      o_halted      = (r_state == ST_HALTED);
      o_state       = r_state;
      o_cycle_count = r_cycle_count;
      o_stall_count = r_stall_count;
   end

endmodule
